// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: RAM op/owner codes, special
// register addresses and the controller FSM states.
package pipe_hazard_ctrl_pkg;

    localparam logic PAUSE_ENABLE = 1'b1;

    localparam logic RAM_OP_RD = 1'b0;
    localparam logic RAM_OP_WR = 1'b1;

    localparam logic RAM_SEL_INST = 1'b0;
    localparam logic RAM_SEL_DATA = 1'b1;

    localparam logic [3:0] REG_SP = 4'd8;
    localparam logic [3:0] REG_IH = 4'd9;
    localparam logic [3:0] REG_RA = 4'd10;
    localparam logic [3:0] REG_T  = 4'd11;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_BUSY = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use comparator: the EXE instruction is a register-writing load whose
// destination is read by the instruction currently in ID.
module hazard_load_use_det
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  id_use_rx,
    input  logic                  id_use_ry,
    input  logic [REG_ADDR_W-1:0] id_rx_addr,
    input  logic [REG_ADDR_W-1:0] id_ry_addr,
    input  logic                  ie_RAM_en,
    input  logic                  ie_RAM_op,
    input  logic                  ie_wb_en,
    input  logic [REG_ADDR_W-1:0] ie_wb_addr,
    output logic                  load_use
);

    logic is_load;
    logic rx_hit;
    logic ry_hit;

    assign is_load  = ie_RAM_en & (ie_RAM_op == RAM_OP_RD) & ie_wb_en;
    assign rx_hit   = id_use_rx & (id_rx_addr == ie_wb_addr);
    assign ry_hit   = id_use_ry & (id_ry_addr == ie_wb_addr);
    assign load_use = is_load & (rx_hit | ry_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: SRAM arbitration FSM, load-use and jump handling, and
// the merge of all causes into per-register hold/flush controls.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_WAIT   = 1,
    parameter int REG_ADDR_W = 4,
    parameter int PERF_W     = 16
) (
    input  logic                  clk_50MHz,
    input  logic                  rst,
    input  logic                  id_use_rx,
    input  logic                  id_use_ry,
    input  logic [REG_ADDR_W-1:0] id_rx_addr,
    input  logic [REG_ADDR_W-1:0] id_ry_addr,
    input  logic                  ie_RAM_en,
    input  logic                  ie_RAM_op,
    input  logic                  ie_wb_en,
    input  logic [REG_ADDR_W-1:0] ie_wb_addr,
    input  logic                  ie_jump_taken,
    input  logic                  em_RAM_en,
    output logic                  pc_hold,
    output logic                  pc_load_target,
    output logic                  ii_hold,
    output logic                  ii_flush,
    output logic                  ie_hold,
    output logic                  ie_PAUSE,
    output logic                  em_hold,
    output logic                  mw_flush,
    output logic                  ram_sel,
    output logic [PERF_W-1:0]     stall_cycles
);

    // cnt counts the remaining hold cycles before the final access cycle
    localparam logic [3:0] CNT_INIT = 4'((MEM_WAIT > 1) ? (MEM_WAIT - 2) : 0);

    ctrl_state_e state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        hold_cyc;
    logic        fin_cyc;
    logic        load_use;
    logic        jump_eff;
    logic        lu_stall;

    hazard_load_use_det #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_lu_det (
        .id_use_rx  (id_use_rx),
        .id_use_ry  (id_use_ry),
        .id_rx_addr (id_rx_addr),
        .id_ry_addr (id_ry_addr),
        .ie_RAM_en  (ie_RAM_en),
        .ie_RAM_op  (ie_RAM_op),
        .ie_wb_en   (ie_wb_en),
        .ie_wb_addr (ie_wb_addr),
        .load_use   (load_use)
    );

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state        <= CTRL_IDLE;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (pc_hold && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hold_cyc = 1'b0;
        fin_cyc  = 1'b0;
        case (state)
            CTRL_IDLE: begin
                if (em_RAM_en) begin
                    if (MEM_WAIT > 1) begin
                        hold_cyc = 1'b1;
                        state_nx = CTRL_BUSY;
                        cnt_nx   = CNT_INIT;
                    end else begin
                        fin_cyc = 1'b1;
                    end
                end
            end
            CTRL_BUSY: begin
                if (cnt != 4'd0) begin
                    hold_cyc = 1'b1;
                    cnt_nx   = cnt - 4'd1;
                end else begin
                    fin_cyc  = 1'b1;
                    state_nx = CTRL_IDLE;
                end
            end
            default: state_nx = CTRL_IDLE;
        endcase
    end

    // The frozen EXE instruction is re-evaluated once the hold releases
    assign jump_eff = ie_jump_taken & ~hold_cyc;
    assign lu_stall = load_use & ~hold_cyc & ~jump_eff;

    always_comb begin
        pc_load_target = jump_eff;
        pc_hold        = (hold_cyc | fin_cyc | lu_stall) & ~jump_eff;
        ii_hold        = hold_cyc | lu_stall;
        ii_flush       = (fin_cyc | jump_eff) & ~ii_hold;
        ie_hold        = hold_cyc;
        ie_PAUSE       = (lu_stall | jump_eff) & PAUSE_ENABLE;
        em_hold        = hold_cyc;
        mw_flush       = hold_cyc;
        ram_sel        = (hold_cyc | fin_cyc) ? RAM_SEL_DATA : RAM_SEL_INST;
        if (rst) begin
            pc_load_target = 1'b0;
            pc_hold        = 1'b0;
            ii_hold        = 1'b0;
            ii_flush       = 1'b1;
            ie_hold        = 1'b0;
            ie_PAUSE       = 1'b1;
            em_hold        = 1'b0;
            mw_flush       = 1'b1;
            ram_sel        = RAM_SEL_INST;
        end
    end

endmodule
